// File: rtl/mac_if_pkg.sv
// Shared MAC receive-path types: address constants, filter FSM states and
// the delay-line entry carried alongside each byte.
package mac_if_pkg;

  localparam int MAC_ADDR_W     = 48;
  localparam int MAC_ADDR_BYTES = 6;
  localparam logic [MAC_ADDR_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    FWD,
    DROP,
    FLUSH
  } rx_filt_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       err;
  } dl_entry_t;

  // Bit MAC_ADDR_W-8 is the I/G bit: bit 0 of the first DA byte on the wire.
  function automatic logic da_accept(input logic [MAC_ADDR_W-1:0] da,
                                     input logic [MAC_ADDR_W-1:0] own,
                                     input logic                  promisc,
                                     input logic                  accept_mcast);
    return (da == own) || (da == BCAST_MAC) || promisc ||
           (da[MAC_ADDR_W-8] && accept_mcast);
  endfunction

endpackage

// File: rtl/rx_byte_delay_line.sv
// Fixed-depth byte delay line. The entry leaving stage 0 can be tagged
// last/err, since end of frame is only visible one cycle after the last byte.
module rx_byte_delay_line
  import mac_if_pkg::*;
#(
  parameter int DELAY_DEPTH = MAC_ADDR_BYTES
) (
  input  logic      clk,
  input  logic      rst,
  input  dl_entry_t in_entry,
  input  logic      tag_last,
  input  logic      tag_err,
  output dl_entry_t tail
);

  dl_entry_t stage_q [DELAY_DEPTH];
  dl_entry_t stage0_tagged;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    stage0_tagged      = stage_q[0];
    stage0_tagged.last = stage_q[0].last | tag_last;
    stage0_tagged.err  = stage_q[0].err  | tag_err;
  end

  // NOTE: this storage is reset on purpose -- stale bytes must never be
  // forwarded after a reset, so the whole line is cleared, not just the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY_DEPTH; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read the old value of its neighbour.
      stage_q[0] <= in_entry;
      for (int i = 1; i < DELAY_DEPTH; i++)
        stage_q[i] <= (i == 1) ? stage0_tagged : stage_q[i-1];
    end
  end

  assign tail = stage_q[DELAY_DEPTH-1];

endmodule

// File: rtl/rx_dst_filter_ctrl.sv
// Destination-MAC frame filter behind rx_mac_top: forwards accepted frames with
// SOF/EOF/ERR framing at a fixed 7-cycle latency. Optional RX_FILTER_STATS_EN adds counters.
module rx_dst_filter_ctrl
  import mac_if_pkg::*;
`ifdef RX_FILTER_STATS_EN
#(
  parameter int STAT_W = 32
)
`endif
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_data_valid_i,
  input  logic                  is_preamble_or_sfd_i,
  input  logic                  is_dst_mac_i,
  input  logic                  is_src_mac_i,
  input  logic                  is_ether_type_i,
  input  logic                  is_payload_or_crc_i,
  input  logic                  invalid_frame_i,
  input  logic [MAC_ADDR_W-1:0] cfg_mac_addr_i,
  input  logic                  cfg_promisc_i,
  input  logic                  cfg_accept_mcast_i,
  output logic [7:0]            out_data_o,
  output logic                  out_valid_o,
  output logic                  out_sof_o,
  output logic                  out_eof_o,
  output logic                  out_err_o
`ifdef RX_FILTER_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_accepted_o,
  output logic [STAT_W-1:0]     stat_dropped_o,
  output logic [STAT_W-1:0]     stat_errored_o
`endif
);

  // The delay must cover the whole DA so the decision precedes the first byte out.
  localparam int DELAY_DEPTH = MAC_ADDR_BYTES;

  rx_filt_state_e          state_q, state_d;
  logic [MAC_ADDR_W-9:0]   da_sr_q;
  logic [2:0]              da_cnt_q;
  logic                    sof_pending_q, flush_err_q, prev_da_q;
  dl_entry_t               in_entry, tail;
  logic                    tag_last, tag_err;
  logic                    push, da_byte, emit, eof_cap, err_cap;
  logic                    reject, runt, dst_abort;

  assign push    = rx_data_valid_i && !is_preamble_or_sfd_i;
  assign da_byte = push && is_dst_mac_i;
  assign emit    = (state_q == FWD) || (state_q == FLUSH);
  assign eof_cap = emit && tail.valid && tail.last;
  assign err_cap = eof_cap &&
                   (tail.err || flush_err_q || ((state_q == FLUSH) && invalid_frame_i));

  always_comb begin
    state_d   = state_q;
    in_entry  = '{data: rx_data_i, valid: push, last: 1'b0, err: 1'b0};
    tag_last  = 1'b0;
    tag_err   = 1'b0;
    reject    = 1'b0;
    runt      = 1'b0;
    dst_abort = 1'b0;
    case (state_q)
      IDLE: if (da_byte) state_d = DST;
      DST: begin
        if (invalid_frame_i) begin
          state_d   = DROP;
          dst_abort = 1'b1;
        end else if (!rx_data_valid_i) begin
          state_d = IDLE;
          runt    = 1'b1;
        end else if (da_byte && (da_cnt_q == 3'(MAC_ADDR_BYTES - 2))) begin
          if (da_accept({da_sr_q, rx_data_i}, cfg_mac_addr_i,
                        cfg_promisc_i, cfg_accept_mcast_i)) begin
            state_d = FWD;
          end else begin
            state_d = DROP;
            reject  = 1'b1;
          end
        end
      end
      FWD: begin
        // An abort tags the byte arriving now, or the newest stored one if none.
        if (invalid_frame_i) begin
          state_d = FLUSH;
          if (push) begin
            in_entry.last = 1'b1;
            in_entry.err  = 1'b1;
          end else begin
            tag_last = 1'b1;
            tag_err  = 1'b1;
          end
        end else if (!rx_data_valid_i) begin
          state_d  = FLUSH;
          tag_last = 1'b1;
        end
      end
      DROP:    if (!rx_data_valid_i) state_d = IDLE;
      FLUSH:   if (eof_cap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  rx_byte_delay_line #(.DELAY_DEPTH(DELAY_DEPTH)) u_delay_line (
    .clk      (clk),
    .rst      (rst),
    .in_entry (in_entry),
    .tag_last (tag_last),
    .tag_err  (tag_err),
    .tail     (tail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      da_sr_q       <= '0;
      da_cnt_q      <= '0;
      sof_pending_q <= 1'b0;
      flush_err_q   <= 1'b0;
      prev_da_q     <= 1'b0;
      out_data_o    <= '0;
      out_valid_o   <= 1'b0;
      out_sof_o     <= 1'b0;
      out_eof_o     <= 1'b0;
      out_err_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_da_q <= da_byte;
      if (da_byte) da_sr_q <= {da_sr_q[MAC_ADDR_W-17:0], rx_data_i};
      if (state_q == IDLE)                da_cnt_q <= '0;
      else if (state_q == DST && da_byte) da_cnt_q <= da_cnt_q + 3'd1;

      if (state_q == DST && state_d == FWD) sof_pending_q <= 1'b1;
      else if (emit && tail.valid)          sof_pending_q <= 1'b0;
      // An abort during FLUSH upgrades the already-tagged last byte to an error.
      flush_err_q <= (state_q == FLUSH) && !eof_cap && (flush_err_q || invalid_frame_i);

      out_valid_o <= emit && tail.valid;
      out_data_o  <= (emit && tail.valid) ? tail.data : 8'h00;
      out_sof_o   <= emit && tail.valid && sof_pending_q;
      out_eof_o   <= eof_cap;
      out_err_o   <= err_cap;
    end
  end

`ifdef RX_FILTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted_o <= '0;
      stat_dropped_o  <= '0;
      stat_errored_o  <= '0;
    end else begin
      if (eof_cap && !err_cap && !(&stat_accepted_o))
        stat_accepted_o <= stat_accepted_o + STAT_W'(1);
      if ((reject || runt) && !(&stat_dropped_o))
        stat_dropped_o <= stat_dropped_o + STAT_W'(1);
      if ((err_cap || dst_abort) && !(&stat_errored_o))
        stat_errored_o <= stat_errored_o + STAT_W'(1);
    end
  end
`else
  logic unused_stat_events;
  assign unused_stat_events = ^{reject, runt, dst_abort};
`endif

  // Field flags other than DA/preamble are implied by position in the stream.
  logic unused_fields;
  assign unused_fields = ^{is_src_mac_i, is_ether_type_i, is_payload_or_crc_i};

  // A fresh DA (not continuing one already in progress) cannot arrive while
  // the previous frame is still being dropped or flushed, given the MAC IFG.
  assert property (@(posedge clk) disable iff (rst)
    !(((state_q == FLUSH) || (state_q == DROP)) && da_byte && !prev_da_q));

endmodule

// File: tb/tb_rx_dst_filter_ctrl.sv
// Randomized self-checking bench for rx_dst_filter_ctrl: a frame-level model
// predicts every output byte and its cycle from the filtering rules.
module tb_rx_dst_filter_ctrl;
  import mac_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, is_pre, is_dst, is_src, is_typ, is_pay, invalid;
  logic [47:0] cfg_mac;
  logic        cfg_promisc, cfg_mcast;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, out_err;
`ifdef RX_FILTER_STATS_EN
  logic [31:0] stat_acc, stat_drop, stat_err;
`endif

  always #5 clk = ~clk;

  rx_dst_filter_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_data_i            (rx_data),
    .rx_data_valid_i      (rx_valid),
    .is_preamble_or_sfd_i (is_pre),
    .is_dst_mac_i         (is_dst),
    .is_src_mac_i         (is_src),
    .is_ether_type_i      (is_typ),
    .is_payload_or_crc_i  (is_pay),
    .invalid_frame_i      (invalid),
    .cfg_mac_addr_i       (cfg_mac),
    .cfg_promisc_i        (cfg_promisc),
    .cfg_accept_mcast_i   (cfg_mcast),
    .out_data_o           (out_data),
    .out_valid_o          (out_valid),
    .out_sof_o            (out_sof),
    .out_eof_o            (out_eof),
    .out_err_o            (out_err)
`ifdef RX_FILTER_STATS_EN
    ,
    .stat_accepted_o      (stat_acc),
    .stat_dropped_o       (stat_drop),
    .stat_errored_o       (stat_err)
`endif
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned cyc = 0;
  logic        rst_smp;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned m_acc = 0, m_drop = 0, m_err = 0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Output monitor: each cycle either the next predicted byte or silence.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_byte", 64'(exp_q[0].data), 64'hFFFF);
        void'(exp_q.pop_front());
      end
      if (rst_smp) begin
        check("reset_outputs", {out_data, out_valid, out_sof, out_eof, out_err}, 0);
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("out_valid", out_valid, 1);
        check("out_data", out_data, e.data);
        check("out_sof", out_sof, e.sof);
        check("out_eof", out_eof, e.eof);
        check("out_err", out_err, e.err);
      end else begin
        check("idle_flags", {out_valid, out_sof, out_eof, out_err}, 0);
      end
    end
  end

  task automatic clear_inputs();
    rx_data = 8'h00; rx_valid = 0; is_pre = 0; is_dst = 0;
    is_src = 0; is_typ = 0; is_pay = 0; invalid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      clear_inputs();
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic pre, input logic dst, input logic src,
                       input logic typ, input logic pay, input logic inv);
    @(posedge clk); #1;
    rx_data = d; rx_valid = 1; is_pre = pre; is_dst = dst;
    is_src = src; is_typ = typ; is_pay = pay; invalid = inv;
  endtask

  // len counts bytes after the SFD; abort_at / rst_at < 0 means none.
  task automatic send_frame(input logic [47:0] da, input int len, input int abort_at,
                            input int rst_at, input int gap);
    logic [7:0] b;
    bit         fwd, aborted, acc_rule;
    int         n_out;
    acc_rule = (da == cfg_mac) || (da == 48'hFFFF_FFFF_FFFF) || cfg_promisc ||
               (da[40] && cfg_mcast);
    aborted  = (abort_at >= 6) && (abort_at < len);
    fwd      = 0;
    n_out    = 0;
    if (len < 6)                             m_drop++;
    else if (abort_at >= 1 && abort_at < 6)  m_err++;
    else if (!acc_rule)                      m_drop++;
    else begin
      fwd   = 1;
      n_out = aborted ? abort_at + 1 : len;
    end
    for (int i = 0; i < 8; i++) drive((i == 7) ? 8'hD5 : 8'h55, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        @(posedge clk); #1;
        clear_inputs();
        rst = 1;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) void'(exp_q.pop_back());
        m_acc = 0; m_drop = 0; m_err = 0;
        @(posedge clk); #1;
        rst = 0;
        break;
      end
      b = (i < 6) ? da[47 - 8*i -: 8] : 8'($urandom);
      drive(b, 0, i < 6, i >= 6 && i < 12, i >= 12 && i < 14, i >= 14, i == abort_at);
      if (fwd && i < n_out)
        exp_q.push_back('{cyc: cyc + 7, data: b, sof: (i == 0), eof: (i == n_out - 1),
                          err: (aborted && i == n_out - 1)});
    end
    if (fwd && rst_at < 0) begin
      if (aborted) m_err++;
      else         m_acc++;
    end
    idle(gap);
  endtask

`ifdef RX_FILTER_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, "_stat_accepted"}, stat_acc, m_acc);
    check({tag, "_stat_dropped"}, stat_drop, m_drop);
    check({tag, "_stat_errored"}, stat_err, m_err);
  endtask
`endif

  initial begin
    logic [47:0] da;
    int          len, abort_at, kind;
    rst = 1;
    clear_inputs();
    cfg_mac     = 48'h00_1A_2B_3C_4D_5E;
    cfg_promisc = 0;
    cfg_mcast   = 0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(4);

    // Own address, full 64-byte frame.
    send_frame(cfg_mac, 64, -1, -1, 12);
    // Foreign unicast is filtered.
    send_frame(48'h02_00_00_00_00_99, 64, -1, -1, 12);
`ifdef RX_FILTER_STATS_EN
    check_stats("after_reject");
`endif
    // Broadcast passes; multicast only when enabled.
    send_frame(48'hFF_FF_FF_FF_FF_FF, 40, -1, -1, 12);
    send_frame(48'h01_00_5E_00_00_01, 40, -1, -1, 12);
    cfg_mcast = 1;
    send_frame(48'h01_00_5E_00_00_01, 40, -1, -1, 12);
    cfg_mcast = 0;
    // Aborts: in payload, in DA; then a runt and a DA-only frame.
    send_frame(cfg_mac, 64, 20, -1, 12);
    send_frame(cfg_mac, 64, 3, -1, 12);
    send_frame(cfg_mac, 4, -1, -1, 12);
    send_frame(cfg_mac, 6, -1, -1, 12);
    // Promiscuous accepts a foreign unicast.
    cfg_promisc = 1;
    send_frame(48'h02_00_00_00_00_99, 30, -1, -1, 12);
    cfg_promisc = 0;
    // Back-to-back at minimum IFG.
    send_frame(cfg_mac, 60, -1, -1, 12);
    send_frame(48'hFF_FF_FF_FF_FF_FF, 60, -1, -1, 12);
`ifdef RX_FILTER_STATS_EN
    check_stats("after_directed");
`endif
    // Reset in the middle of forwarding, then a normal frame.
    send_frame(cfg_mac, 60, -1, 30, 12);
    send_frame(cfg_mac, 50, -1, -1, 12);

    // Randomized frames and configuration.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(3);
      case (kind)
        0:       da = cfg_mac;
        1:       da = 48'hFF_FF_FF_FF_FF_FF;
        2:       da = {8'($urandom) | 8'h01, 8'($urandom), 32'($urandom)};
        default: da = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
      endcase
      cfg_promisc = ($urandom_range(3) == 0);
      cfg_mcast   = $urandom_range(1);
      len         = ($urandom_range(7) == 0) ? $urandom_range(5, 1) : $urandom_range(90, 6);
      abort_at    = -1;
      if (len > 6 && $urandom_range(5) == 0)
        abort_at = ($urandom_range(1) == 0) ? $urandom_range(5, 1) : $urandom_range(len - 1, 6);
      send_frame(da, len, abort_at, -1, 12);
    end

    idle(20);
    check("queue_drained", 64'(exp_q.size()), 0);
`ifdef RX_FILTER_STATS_EN
    check_stats("final");
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
